// File: rtl/mac_dot_sequencer_pkg.sv
// Shared constants and state encoding for the MAC dot-product sequencer.
package mac_dot_sequencer_pkg;

  localparam int unsigned MacOpW        = 18;  // MAC operand width
  localparam int unsigned MacAccW       = 48;  // MAC accumulator width
  localparam int unsigned MacLatDefault = 3;   // default MAC latency

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StFetch = 2'd2,
    StDrain = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Address generator: latches both base addresses and the pair count, then
// steps the two read addresses once per cycle while fetching.
module mac_seq_addr_gen #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,      // latch bases and length
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] length,
  input  logic              go,        // begin stepping next cycle
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              zero_len,  // latched length is zero
  output logic              last,      // current address is the last pair
  output logic              rd_en
);

  logic [ADDR_W-1:0] x_addr_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [ADDR_W-1:0] remain_q;
  logic              active_q;

  // Address registers wrap naturally modulo 2^ADDR_W.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_addr_q <= '0;
      w_addr_q <= '0;
      remain_q <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      x_addr_q <= x_base;
      w_addr_q <= w_base;
      remain_q <= length;
      active_q <= 1'b0;
    end else if (go) begin
      active_q <= 1'b1;
    end else if (active_q) begin
      x_addr_q <= x_addr_q + ADDR_W'(1);
      w_addr_q <= w_addr_q + ADDR_W'(1);
      remain_q <= remain_q - ADDR_W'(1);
      if (last) active_q <= 1'b0;
    end
  end

  assign x_addr   = x_addr_q;
  assign w_addr   = w_addr_q;
  assign zero_len = (remain_q == '0);
  assign last     = active_q && (remain_q == ADDR_W'(1));
  assign rd_en    = active_q;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences the shared MAC through one dot product: clear, fetch LENGTH
// operand pairs, wait out the MAC pipeline, then return the accumulated sum.
// Optional build macro MAC_SEQ_RELU_EN clamps a negative result to zero.
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MAC_LAT = MacLatDefault
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic [ADDR_W-1:0]         LENGTH,
  input  logic [ADDR_W-1:0]         X_BASE,
  input  logic [ADDR_W-1:0]         W_BASE,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [MacAccW-1:0]        RESULT,
  output logic [ADDR_W-1:0]         X_ADDR,
  output logic [ADDR_W-1:0]         W_ADDR,
  output logic                      RD_EN,
  input  logic signed [MacOpW-1:0]  X_DATA,
  input  logic signed [MacOpW-1:0]  W_DATA,
  output logic signed [MacOpW-1:0]  MAC_A,
  output logic signed [MacOpW-1:0]  MAC_B,
  output logic                      MAC_CLEAR,
  output logic                      MAC_START,
  input  logic signed [MacAccW-1:0] MAC_P
);

  // Drain spans MAC_LAT+2 cycles: read return, operand register, MAC latency.
  localparam int unsigned    CntW      = $clog2(MAC_LAT + 2);
  localparam logic [CntW-1:0] DrainLast = CntW'(MAC_LAT + 1);

  seq_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [MacAccW-1:0]  result_q, result_d;
  logic                done_q, done_d;
  logic                load;
  logic                go;
  logic                zero_len;
  logic                last;
  logic                rd_en;
  logic                rd_vld_q;
  logic signed [MacOpW-1:0] mac_a_q, mac_b_q;
  logic                mac_start_q;

  mac_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load),
    .x_base   (X_BASE),
    .w_base   (W_BASE),
    .length   (LENGTH),
    .go       (go),
    .x_addr   (X_ADDR),
    .w_addr   (W_ADDR),
    .zero_len (zero_len),
    .last     (last),
    .rd_en    (rd_en)
  );

  assign go = (state_q == StClear) && !zero_len;

  // Control state, drain counter, result and done pulse registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state decode; START is only looked at while idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          load    = 1'b1;
          state_d = StClear;
        end
      end
      StClear: begin
        if (zero_len) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          result_d = '0;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        cnt_d = '0;
        if (last) state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
`ifdef MAC_SEQ_RELU_EN
          result_d = MAC_P[MacAccW-1] ? '0 : MAC_P;
`else
          result_d = MAC_P;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Issue pipeline: read data returned this cycle becomes the next MAC operand pair.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_vld_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_start_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_vld_q) begin
        mac_a_q     <= X_DATA;
        mac_b_q     <= W_DATA;
        mac_start_q <= ~mac_start_q;
      end
    end
  end

  assign BUSY      = (state_q != StIdle);
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign RD_EN     = rd_en;
  assign MAC_A     = mac_a_q;
  assign MAC_B     = mac_b_q;
  assign MAC_CLEAR = (state_q == StClear);
  assign MAC_START = mac_start_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized self-checking bench for mac_dot_sequencer with a behavioural
// MAC and memory, and a run-level reference model checked every cycle.
module tb_mac_dot_sequencer;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic               CLK;
  logic               RESET;
  logic               START;
  logic [AW-1:0]      LENGTH, X_BASE, W_BASE;
  logic               BUSY, DONE, RD_EN, MAC_CLEAR, MAC_START;
  logic [47:0]        RESULT;
  logic [AW-1:0]      X_ADDR, W_ADDR;
  logic signed [17:0] X_DATA, W_DATA, MAC_A, MAC_B;
  logic signed [47:0] MAC_P;

  mac_dot_sequencer #(
    .ADDR_W  (AW),
    .MAC_LAT (LAT)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .LENGTH    (LENGTH),
    .X_BASE    (X_BASE),
    .W_BASE    (W_BASE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .X_ADDR    (X_ADDR),
    .W_ADDR    (W_ADDR),
    .RD_EN     (RD_EN),
    .X_DATA    (X_DATA),
    .W_DATA    (W_DATA),
    .MAC_A     (MAC_A),
    .MAC_B     (MAC_B),
    .MAC_CLEAR (MAC_CLEAR),
    .MAC_START (MAC_START),
    .MAC_P     (MAC_P)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memories: synchronous read, one cycle latency.
  logic signed [17:0] xmem [1024];
  logic signed [17:0] wmem [1024];
  initial begin
    X_DATA = '0;
    W_DATA = '0;
  end
  always @(posedge CLK) begin
    if (RD_EN === 1'b1) begin
      X_DATA <= xmem[X_ADDR];
      W_DATA <= wmem[W_ADDR];
    end
  end

  // Behavioural MAC: a pair whose toggle is visible in cycle c is summed into MAC_P by c+LAT.
  logic               pv [LAT];
  logic signed [47:0] pp [LAT];
  logic signed [47:0] acc;
  logic               mac_prev;
  longint             prod;
  initial begin
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pp[i] = '0;
    end
    acc      = '0;
    mac_prev = 1'b0;
    MAC_P    = '0;
  end
  always @(posedge CLK) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pp[i] = pp[i-1];
    end
    prod  = longint'(MAC_A) * longint'(MAC_B);
    pv[0] = (MAC_START !== mac_prev) && !$isunknown(MAC_START) && !$isunknown(mac_prev);
    pp[0] = prod[47:0];
    mac_prev = MAC_START;
    if (MAC_CLEAR === 1'b1) acc = '0;
    if (pv[LAT-1]) acc = acc + pp[LAT-1];
    MAC_P <= acc;
  end

  // Reference model: one accepted run described by its start cycle and operands.
  bit          chk_en = 0;
  bit          rst_chk = 1;
  bit          m_active = 0;
  int          m_start = 0, m_len = 0, m_xb = 0, m_wb = 0, m_done_rel = 0;
  logic [47:0] m_exp = '0, m_held = '0;
  logic        prev_start = 1'b0;
  int          rel, k;
  logic        tog, e_busy, e_done, e_clr, e_rd, e_tog;
  longint      sum;
  int          tog_seen = 0, clr_seen = 0, done_seen = 0, rd_seen = 0;
  logic [AW-1:0] xq [$];

  // Per-cycle comparison of every output against the run-level model.
  always @(negedge CLK) begin
    tog    = (MAC_START !== prev_start);
    rel    = cyc - m_start;
    e_busy = m_active && rel >= 1 && rel < m_done_rel;
    e_done = m_active && rel == m_done_rel;
    e_clr  = m_active && rel == 1;
    e_rd   = m_active && m_len > 0 && rel >= 2 && rel < 2 + m_len;
    e_tog  = m_active && m_len > 0 && rel >= 4 && rel < 4 + m_len;
    if (e_done) m_held = m_exp;
    if (chk_en) begin
      chk("busy", BUSY, e_busy);
      chk("done", DONE, e_done);
      chk("mac_clear", MAC_CLEAR, e_clr);
      chk("rd_en", RD_EN, e_rd);
      chk("result", RESULT, m_held);
      if (e_rd) begin
        chk("x_addr", X_ADDR, (m_xb + rel - 2) % 1024);
        chk("w_addr", W_ADDR, (m_wb + rel - 2) % 1024);
      end
      if (rst_chk) begin
        chk("rst_x_addr", X_ADDR, 0);
        chk("rst_w_addr", W_ADDR, 0);
        chk("rst_mac_a", MAC_A, 0);
        chk("rst_mac_b", MAC_B, 0);
        chk("rst_mac_start", MAC_START, 0);
      end else begin
        chk("mac_start_toggle", tog, e_tog);
        if (e_tog) begin
          k = rel - 4;
          chk("mac_a", MAC_A, xmem[(m_xb + k) % 1024]);
          chk("mac_b", MAC_B, wmem[(m_wb + k) % 1024]);
        end
        if (tog) tog_seen++;
      end
      if (MAC_CLEAR === 1'b1) clr_seen++;
      if (DONE === 1'b1) done_seen++;
      if (RD_EN === 1'b1) begin
        rd_seen++;
        xq.push_back(X_ADDR);
      end
    end
    if (e_done) m_active = 0;
    if (RESET === 1'b1) begin
      m_active = 0;
      m_held   = '0;
    end else if (START === 1'b1 && !m_active) begin
      m_active   = 1;
      m_start    = cyc;
      m_len      = int'(LENGTH);
      m_xb       = int'(X_BASE);
      m_wb       = int'(W_BASE);
      m_done_rel = (m_len == 0) ? 2 : m_len + 4 + LAT;
      sum = 0;
      for (int j = 0; j < m_len; j++)
        sum += longint'(xmem[(m_xb + j) % 1024]) * longint'(wmem[(m_wb + j) % 1024]);
      m_exp = sum[47:0];
`ifdef MAC_SEQ_RELU_EN
      if (m_exp[47]) m_exp = '0;
`endif
    end
    rst_chk    = (RESET === 1'b1);
    prev_start = MAC_START;
  end

  // Issue one request and wait (bounded) for DONE; optional stray START / mid-run reset.
  task automatic run(input int l, input int xb, input int wb, input int extra, input int rst_at,
                     output int lat, output bit got);
    int s;
    LENGTH = AW'(l);
    X_BASE = AW'(xb);
    W_BASE = AW'(wb);
    START  = 1'b1;
    s   = cyc;
    got = 0;
    lat = -1;
    for (int n = 0; n < 400; n++) begin
      @(posedge CLK); #1;
      START = ((cyc - s) == extra);
      RESET = ((cyc - s) == rst_at);
      if (DONE === 1'b1) begin
        got = 1;
        lat = cyc - s;
        break;
      end
      if (rst_at >= 0 && (cyc - s) > rst_at) break;
    end
    START = 1'b0;
    RESET = 1'b0;
    if (!got && rst_at < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  int lat, t0, c0, d0, r0, l, xb, wb, extra;
  bit got;

  initial begin
    RESET = 1'b1; START = 1'b0; LENGTH = '0; X_BASE = '0; W_BASE = '0;
    for (int i = 0; i < 1024; i++) begin
      xmem[i] = 18'($urandom);
      wmem[i] = 18'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      xmem[100 + i] = 18'(i + 1);
      wmem[200 + i] = 18'(i + 5);
    end
    xmem[300] = -18'sd3;
    wmem[301] = 18'sd5;
    repeat (3) @(posedge CLK);
    #1;
    chk_en = 1;
    RESET  = 1'b0;
    idle(2);

    // Basic dot product
    t0 = tog_seen; c0 = clr_seen;
    run(4, 100, 200, -1, -1, lat, got);
    chk("basic_latency", lat, 11);
    chk("basic_result", RESULT, 48'd70);
    chk("basic_toggles", tog_seen - t0, 4);
    chk("basic_clears", clr_seen - c0, 1);
    idle(2);

    // Negative result
    run(1, 300, 301, -1, -1, lat, got);
`ifdef MAC_SEQ_RELU_EN
    chk("neg_result", RESULT, 48'h0);
`else
    chk("neg_result", RESULT, 48'hFFFF_FFFF_FFF1);
`endif
    idle(1);

    // Zero length
    t0 = tog_seen; r0 = rd_seen;
    run(0, 5, 6, -1, -1, lat, got);
    chk("zero_latency", lat, 2);
    chk("zero_result", RESULT, 0);
    chk("zero_rd_en", rd_seen - r0, 0);
    chk("zero_toggles", tog_seen - t0, 0);
    idle(1);

    // Address wrap
    xq.delete();
    run(4, 1022, 7, -1, -1, lat, got);
    chk("wrap_count", xq.size(), 4);
    if (xq.size() == 4) begin
      chk("wrap_a0", xq[0], 1022);
      chk("wrap_a1", xq[1], 1023);
      chk("wrap_a2", xq[2], 0);
      chk("wrap_a3", xq[3], 1);
    end
    idle(1);

    // Ignored START in cycle 5
    d0 = done_seen;
    run(8, 40, 600, 5, -1, lat, got);
    idle(4);
    chk("ignored_start_dones", done_seen - d0, 1);

    // Reset mid-run, then a fresh basic run
    d0 = done_seen;
    run(8, 10, 20, -1, 4, lat, got);
    chk("rst_no_done_seen", got, 0);
    idle(4);
    chk("rst_dones", done_seen - d0, 0);
    run(4, 100, 200, -1, -1, lat, got);
    chk("post_rst_result", RESULT, 48'd70);

    // Randomized runs, including back-to-back starts and stray STARTs
    for (int r = 0; r < 24; r++) begin
      l  = $urandom_range(0, 24);
      xb = $urandom_range(0, 1023);
      wb = $urandom_range(0, 1023);
      extra = (l > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, l + 3) : -1;
      run(l, xb, wb, extra, -1, lat, got);
      chk("rand_latency", lat, (l == 0) ? 2 : l + 4 + LAT);
      idle($urandom_range(0, 2));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
